// File: rtl/and_gate_pkg.sv
// Shared definitions for the and_gate cell: lane-0 input-combination encoding
// and default statistics counter width.
package and_gate_pkg;

    localparam int CNT_W_DEFAULT = 16;

    // Lane-0 input combination, encoded as {a[0], b[0]}.
    typedef enum logic [1:0] {
        COMBO_00 = 2'b00,
        COMBO_01 = 2'b01,
        COMBO_10 = 2'b10,
        COMBO_11 = 2'b11
    } combo_e;

    function automatic combo_e combo_of(input logic a0, input logic b0);
        return combo_e'({a0, b0});
    endfunction

endpackage : and_gate_pkg

// File: rtl/and_gate_stats.sv
// Registered copy of y plus bring-up statistics: sticky lane-0 combination
// flags, a saturating all-ones counter and a saturating toggle counter.
module and_gate_stats
    import and_gate_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] y,
    input  logic             all_ones,
    input  combo_e           combo,
    output logic [WIDTH-1:0] y_q,
    output logic [3:0]       combo_seen,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] y_q_d, y_q_q;
    logic [WIDTH-1:0] y_prev_d, y_prev_q;
    logic [3:0]       seen_d, seen_q;
    logic [CNT_W-1:0] high_d, high_q;
    logic [CNT_W-1:0] tog_d, tog_q;

    // Next-state: clear wipes statistics without counting the clearing sample.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        y_q_d    = y;
        y_prev_d = y;
        seen_d   = seen_q;
        high_d   = high_q;
        tog_d    = tog_q;
        if (clr) begin
            seen_d = 4'b0000;
            high_d = '0;
            tog_d  = '0;
        end else begin
            seen_d[combo] = 1'b1;
            if (all_ones && (high_q != CNT_MAX)) begin
                high_d = high_q + CNT_ONE;
            end
            if ((y != y_prev_q) && (tog_q != CNT_MAX)) begin
                tog_d = tog_q + CNT_ONE;
            end
        end
    end

    // State registers with synchronous reset taking priority over clear.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            y_q_q    <= '0;
            y_prev_q <= '0;
            seen_q   <= 4'b0000;
            high_q   <= '0;
            tog_q    <= '0;
        end else begin
            y_q_q    <= y_q_d;
            y_prev_q <= y_prev_d;
            seen_q   <= seen_d;
            high_q   <= high_d;
            tog_q    <= tog_d;
        end
    end

    assign y_q        = y_q_q;
    assign combo_seen = seen_q;
    assign high_cnt   = high_q;
    assign toggle_cnt = tog_q;

endmodule : and_gate_stats

// File: rtl/and_gate.sv
// Lane-wise 2-input AND. The combinational path depends only on a and b, so
// the cell works with clk/rst/clr left unconnected; statistics are optional.
module and_gate
    import and_gate_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    input  logic             clr,
    output logic [WIDTH-1:0] y_q,
    output logic             all_ones,
    output logic [3:0]       combo_seen,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] toggle_cnt
);

    assign y        = a & b;
    assign all_ones = &y;

    and_gate_stats #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_stats (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .y          (y),
        .all_ones   (all_ones),
        .combo      (combo_of(a[0], b[0])),
        .y_q        (y_q),
        .combo_seen (combo_seen),
        .high_cnt   (high_cnt),
        .toggle_cnt (toggle_cnt)
    );

endmodule : and_gate

// File: tb/tb_and_gate.sv
// Scoreboard bench for and_gate: the stimulus process predicts the post-edge
// outputs from a behavioural model and queues them; the monitor pops and
// compares one entry after every rising edge.
module tb_and_gate;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        int unsigned y;
        int unsigned all_ones;
        int unsigned y_q;
        int unsigned seen;
        int unsigned high;
        int unsigned tog;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [WIDTH-1:0] y, y_q;
    logic             all_ones;
    logic [3:0]       combo_seen;
    logic [CNT_W-1:0] high_cnt, toggle_cnt;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model state: plain integers and a set of seen combinations.
    bit   m_seen[4];
    int   m_high, m_tog;
    int   m_prev;

    and_gate #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .y          (y),
        .clr        (clr),
        .y_q        (y_q),
        .all_ones   (all_ones),
        .combo_seen (combo_seen),
        .high_cnt   (high_cnt),
        .toggle_cnt (toggle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int unsigned model_and(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        int unsigned r = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (av[i] === 1'b1 && bv[i] === 1'b1) r += (1 << i);
        end
        return r;
    endfunction

    // Apply one cycle of stimulus at the falling edge and predict the result.
    task automatic step(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic r, input logic c);
        exp_t e;
        int   idx;
        @(negedge clk);
        a = av; b = bv; rst = r; clr = c;
        e.y        = model_and(av, bv);
        e.all_ones = (e.y == (1 << WIDTH) - 1) ? 1 : 0;
        idx = (av[0] ? 2 : 0) + (bv[0] ? 1 : 0);
        if (r) begin
            e.y_q = 0;
            foreach (m_seen[k]) m_seen[k] = 0;
            m_high = 0; m_tog = 0; m_prev = 0;
        end else if (c) begin
            e.y_q = e.y;
            foreach (m_seen[k]) m_seen[k] = 0;
            m_high = 0; m_tog = 0; m_prev = int'(e.y);
        end else begin
            e.y_q = e.y;
            m_seen[idx] = 1;
            if (e.all_ones == 1) m_high = (m_high + 1 > CMAX) ? CMAX : m_high + 1;
            if (int'(e.y) != m_prev) m_tog = (m_tog + 1 > CMAX) ? CMAX : m_tog + 1;
            m_prev = int'(e.y);
        end
        e.seen = 0;
        for (int k = 0; k < 4; k++) if (m_seen[k]) e.seen += (1 << k);
        e.high = m_high;
        e.tog  = m_tog;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry is consumed after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("y",          y,          e.y);
                check("all_ones",   all_ones,   e.all_ones);
                check("y_q",        y_q,        e.y_q);
                check("combo_seen", combo_seen, e.seen);
                check("high_cnt",   high_cnt,   e.high);
                check("toggle_cnt", toggle_cnt, e.tog);
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] ones = '1;
        foreach (m_seen[k]) m_seen[k] = 0;
        m_high = 0; m_tog = 0; m_prev = 0;

        // Reset for two cycles.
        step('0, '0, 1'b1, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        // Lane-0 combinations 00, 01, 10, 11 (last one all ones).
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0001, 1'b0, 1'b0);
        step(4'b0001, 4'b0000, 1'b0, 1'b0);
        step(ones,    ones,    1'b0, 1'b0);
        // Clear, then hold all ones 5 cycles and drop for 1.
        step('0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(ones, ones, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        // Mixed lanes: 1100 & 1010 = 1000.
        step(4'b1100, 4'b1010, 1'b0, 1'b0);
        // Saturation of high_cnt and the hold at maximum.
        for (int i = 0; i < CMAX + 4; i++) step(ones, ones, 1'b0, 1'b0);
        // Reset mid-run while y stays all ones.
        step(ones, ones, 1'b1, 1'b0);
        step(ones, ones, 1'b0, 1'b0);
        // Randomised traffic with occasional clear and reset.
        for (int i = 0; i < 400; i++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            if ($urandom_range(0, 2) == 0) ra = ones;
            if ($urandom_range(0, 2) == 0) rb = ones;
            step(ra, rb, ($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0));
        end
        // Toggle saturation: alternate y for many cycles.
        for (int i = 0; i < 2 * CMAX + 4; i++) step(ones, (i % 2) ? ones : '0, 1'b0, 1'b0);

        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_and_gate
